// File: rtl/t03_rx_pkg.sv
// Shared types and constants for the host-link receive buffer.
package t03_rx_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } rx_state_t;

endpackage

// File: rtl/t03_sync2.sv
// Two-flop level synchronizer, asynchronous reset to 0.
module t03_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/t03_rx_buffer.sv
// Host-link receive FIFO: level/ack handshake on the host side, first-word fall-through pop side.
// Build option T03_RX_OVERRUN_EN: drop bytes while full and flag overrun instead of stalling the host.
module t03_rx_buffer
    import t03_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     hz100,
    input  logic                     reset,
    input  logic [7:0]               rxdata,
    input  logic                     rxready,
    output logic                     rxclk,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic rx_s;

    t03_sync2 u_sync (
        .clk (hz100),
        .rst (reset),
        .d   (rxready),
        .q   (rx_s)
    );

    rx_state_t      state_q, state_d;
    logic           rxclk_q, rxclk_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  rd_nxt;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic [7:0]     mem [DEPTH];
    logic           push, pop, full_w, empty_w;
`ifdef T03_RX_OVERRUN_EN
    logic           drop;
    logic           overrun_q, overrun_d;
`endif

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Space is judged from the registered count, so a same-cycle pop never frees room for a push.
    always_comb begin
        state_d = state_q;
        rxclk_d = 1'b0;
        push    = 1'b0;
`ifdef T03_RX_OVERRUN_EN
        drop    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_s) begin
                    if (!full_w) begin
                        push    = 1'b1;
                        state_d = ACK;
                        rxclk_d = 1'b1;
                    end
`ifdef T03_RX_OVERRUN_EN
                    else begin
                        drop    = 1'b1;
                        state_d = ACK;
                        rxclk_d = 1'b1;
                    end
`endif
                end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!rx_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = rd_en && !empty_w;
        rd_nxt   = rd_ptr_q + AW'(1);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_nxt : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // Registered head: after a pop it is the next stored byte, or the byte being pushed
        // if that pop empties the stored contents; it holds its last value while empty.
        rd_data_d = rd_data_q;
        if (pop) begin
            if (count_q == CW'(1)) begin
                if (push) rd_data_d = rxdata;
            end else begin
                rd_data_d = mem[rd_nxt];
            end
        end else if (push && empty_w) begin
            rd_data_d = rxdata;
        end
    end

    always_ff @(posedge hz100) begin
        if (push) mem[wr_ptr_q] <= rxdata;
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rxclk_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            rxclk_q   <= rxclk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef T03_RX_OVERRUN_EN
    assign overrun_d = overrun_q | drop;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign rxclk   = rxclk_q;
    assign rd_data = rd_data_q;
    assign empty   = empty_w;
    assign full    = full_w;
    assign count   = count_q;

endmodule

// File: tb/tb_t03_rx_buffer.sv
// Directed bench for t03_rx_buffer: host driver tasks, pop-side scoreboard monitor, summary report.
module tb_t03_rx_buffer;

    localparam int DEPTH = 8;

    logic       hz100 = 1'b0;
    logic       reset;
    logic [7:0] rxdata;
    logic       rxready;
    logic       rxclk;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overrun;

    int tests   = 0;
    int fails   = 0;
    int ack_cnt = 0;
    logic [7:0] exp_q[$];

    t03_rx_buffer #(.DEPTH(DEPTH)) dut (
        .hz100   (hz100),
        .reset   (reset),
        .rxdata  (rxdata),
        .rxready (rxready),
        .rxclk   (rxclk),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overrun (overrun)
    );

    always #5 hz100 = ~hz100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head; rxclk pulses are counted.
    always @(negedge hz100) begin
        if (rxclk === 1'b1) ack_cnt++;
        if (reset === 1'b0 && rd_en === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h with nothing expected", rd_data);
            end else begin
                check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hz100);
            #1;
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(posedge hz100);
            #1;
            lat++;
        end while (rxclk !== 1'b1 && lat < 40);
        if (rxclk !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: rxclk still %b after %0d cycles, required 1", rxclk, lat);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit store);
        int lat;
        rxdata  = b;
        rxready = 1'b1;
        if (store) exp_q.push_back(b);
        wait_ack(lat);
        tick(1);
        rxready = 1'b0;
        tick(4);
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        tick(n);
        rd_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ack0;
        int lat;
        reset   = 1'b1;
        rxready = 1'b0;
        rxdata  = 8'h00;
        rd_en   = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_empty",   empty,   1);
        check("rst_full",    full,    0);
        check("rst_count",   count,   0);
        check("rst_rxclk",   rxclk,   0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 8'h00);

        // Single byte, rxready held for 10 cycles.
        ack0    = ack_cnt;
        rxdata  = 8'hA5;
        rxready = 1'b1;
        exp_q.push_back(8'hA5);
        tick(2);
        check("a5_rxclk_before", rxclk, 0);
        tick(1);
        check("a5_rxclk_cycle4", rxclk, 1);
        tick(1);
        check("a5_rxclk_width", rxclk, 0);
        tick(6);
        rxready = 1'b0;
        tick(4);
        check("a5_ack_pulses", ack_cnt - ack0, 1);
        check("a5_empty", empty, 0);
        check("a5_rd_data", rd_data, 8'hA5);
        check("a5_count", count, 1);
        pop_n(1);
        check("a5_empty_after_pop", empty, 1);

        // Pop while empty is ignored.
        pop_n(1);
        check("empty_pop_count", count, 0);
        check("empty_pop_empty", empty, 1);
        check("empty_pop_rd_data", rd_data, 8'hA5);

        // Fill/drain burst, then a second burst across the pointer wrap.
        for (int i = 1; i <= 8; i++) begin
            send(i[7:0], 1'b1);
            if (i == 7) check("burst1_not_full_at7", full, 0);
        end
        check("burst1_full", full, 1);
        check("burst1_count", count, 8);
        pop_n(8);
        check("burst1_drained", empty, 1);
        for (int i = 9; i <= 16; i++) send(i[7:0], 1'b1);
        check("burst2_full", full, 1);
        pop_n(8);
        check("burst2_drained", empty, 1);

        // Full FIFO, ninth byte offered.
        for (int i = 0; i < 8; i++) send(8'h20 + i[7:0], 1'b1);
        check("ovf_full", full, 1);
        ack0    = ack_cnt;
        rxdata  = 8'hFF;
        rxready = 1'b1;
`ifdef T03_RX_OVERRUN_EN
        wait_ack(lat);
        tick(1);
        rxready = 1'b0;
        tick(4);
        check("ovf_ack_pulses", ack_cnt - ack0, 1);
        check("ovf_count", count, 8);
        check("ovf_overrun", overrun, 1);
        pop_n(8);
        check("ovf_drained", empty, 1);
        check("ovf_overrun_sticky", overrun, 1);
`else
        tick(10);
        check("ovf_no_ack", ack_cnt - ack0, 0);
        check("ovf_count_held", count, 8);
        exp_q.push_back(8'hFF);
        pop_n(1);
        wait_ack(lat);
        check("ovf_ack_after_pop_lat", lat, 1);
        tick(1);
        rxready = 1'b0;
        tick(4);
        check("ovf_ack_pulses", ack_cnt - ack0, 1);
        check("ovf_count_refilled", count, 8);
        pop_n(8);
        check("ovf_drained", empty, 1);
        check("ovf_overrun_tied", overrun, 0);
`endif

        // Simultaneous push and pop at count=3.
        send(8'h31, 1'b1);
        send(8'h32, 1'b1);
        send(8'h33, 1'b1);
        check("sim_count_before", count, 3);
        rxdata  = 8'h34;
        rxready = 1'b1;
        exp_q.push_back(8'h34);
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("sim_rxclk", rxclk, 1);
        check("sim_count_after", count, 3);
        tick(1);
        rxready = 1'b0;
        tick(4);
        pop_n(3);
        check("sim_drained", empty, 1);

        // Reset during ACK with two bytes held.
        send(8'h41, 1'b1);
        rxdata  = 8'h55;
        rxready = 1'b1;
        tick(3);
        check("rst_ack_rxclk_pre", rxclk, 1);
        check("rst_ack_count_pre", count, 2);
        reset = 1'b1;
        #1;
        check("rst_ack_rxclk", rxclk, 0);
        check("rst_ack_count", count, 0);
        check("rst_ack_empty", empty, 1);
        exp_q.delete();
        exp_q.push_back(8'h55);
        tick(2);
        reset = 1'b0;
        wait_ack(lat);
        check("rst_release_lat", lat, 3);
        tick(1);
        rxready = 1'b0;
        tick(4);
        check("rst_release_count", count, 1);
        check("rst_release_rd_data", rd_data, 8'h55);
        pop_n(1);
        check("final_empty", empty, 1);
        check("scoreboard_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
